// File: rtl/dhm_pwr_seq.sv
// dhm_pwr_seq: power-down/power-up sequencer for the dhm switchable core domain.
// Lives in the always-on domain and steps the core domain through stop, drain,
// retention save, isolation, reset and power-off, and back in reverse order.
//
// Optional feature: define DHM_PWR_SEQ_TIMEOUT_EN to bound every acknowledge
// wait by TIMEOUT cycles and raise the sticky err flag when a wait expires.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   sleep_req       1 = put domain to sleep, 0 = keep/bring awake (level)
//   rreg_stop_ack   core has stopped accepting traffic
//   pd_ack          power-down handshake acknowledge
//   pwr_good        domain supply up
//   rreg_stop_req   stop request to the core
//   pd_req          power-down request
//   rreg_save       retention save strobe
//   rreg_restore    retention restore strobe
//   pd_iso/pd_iso_n isolation enable and its complement (separate flops)
//   pd_reset_n      domain reset, active low
//   pwr_en          power switch enable
//   asleep          domain fully off
//   busy            sequence in progress
//   err             sticky acknowledge timeout (0 when feature compiled out)
module dhm_pwr_seq #(
   parameter int unsigned SAVE_CYC    = 2,
   parameter int unsigned RESTORE_CYC = 2,
   parameter int unsigned ISO_SETTLE  = 4,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sleep_req,
   input  logic rreg_stop_ack,
   input  logic pd_ack,
   input  logic pwr_good,
   output logic rreg_stop_req,
   output logic pd_req,
   output logic rreg_save,
   output logic rreg_restore,
   output logic pd_iso,
   output logic pd_iso_n,
   output logic pd_reset_n,
   output logic pwr_en,
   output logic asleep,
   output logic busy,
   output logic err
);

   localparam int unsigned CNT_W = 16;

   // Counter load values: the counter runs N-1 down to 0, giving N cycles.
   localparam logic [CNT_W-1:0] SAVE_LD    = CNT_W'(SAVE_CYC - 1);
   localparam logic [CNT_W-1:0] RESTORE_LD = CNT_W'(RESTORE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(ISO_SETTLE - 1);
   localparam logic [CNT_W-1:0] TMO_LD     = CNT_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_ON,
      ST_STOP,
      ST_DRAIN,
      ST_SAVE,
      ST_ISO,
      ST_RST,
      ST_PWROFF,
      ST_OFF,
      ST_PWRON,
      ST_PWR_SETTLE,
      ST_RESTORE,
      ST_UNISO,
      ST_REL_PD,
      ST_REL_STOP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_zero_c;
   logic             tmo_c;
   logic             err_set_c;

   logic stop_c;
   logic pdreq_c;
   logic save_c;
   logic restore_c;
   logic iso_c;
   logic rstn_c;
   logic pwren_c;
   logic asleep_c;
   logic busy_c;

   assign cnt_zero_c = (cnt == '0);

   // The shared counter doubles as the acknowledge-wait timer when enabled.
`ifdef DHM_PWR_SEQ_TIMEOUT_EN
   assign tmo_c = cnt_zero_c;
`else
   assign tmo_c = 1'b0;
`endif

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_ON;
         cnt           <= '0;
         rreg_stop_req <= 1'b0;
         pd_req        <= 1'b0;
         rreg_save     <= 1'b0;
         rreg_restore  <= 1'b0;
         pd_iso        <= 1'b0;
         pd_iso_n      <= 1'b1;
         pd_reset_n    <= 1'b1;
         pwr_en        <= 1'b1;
         asleep        <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rreg_stop_req <= stop_c;
         pd_req        <= pdreq_c;
         rreg_save     <= save_c;
         rreg_restore  <= restore_c;
         pd_iso        <= iso_c;
         pd_iso_n      <= ~iso_c;
         pd_reset_n    <= rstn_c;
         pwr_en        <= pwren_c;
         asleep        <= asleep_c;
         busy          <= busy_c;
         err           <= err | err_set_c;
      end
   end

   // Next state and counter. Abort (sleep_req low) wins over an ack in the
   // same cycle; an ack wins over a timeout.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_zero_c ? cnt : cnt - CNT_W'(1);
      err_set_c = 1'b0;

      case (state)
         ST_ON: begin
            if (sleep_req) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (!sleep_req)         state_nxt = ST_REL_PD;
            else if (rreg_stop_ack) state_nxt = ST_DRAIN;
            else if (tmo_c) begin
               state_nxt = ST_REL_PD;
               err_set_c = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!sleep_req)  state_nxt = ST_REL_PD;
            else if (pd_ack) state_nxt = ST_SAVE;
            else if (tmo_c) begin
               state_nxt = ST_REL_PD;
               err_set_c = 1'b1;
            end
         end
         ST_SAVE: begin
            if (cnt_zero_c) state_nxt = ST_ISO;
         end
         ST_ISO: begin
            if (cnt_zero_c) state_nxt = ST_RST;
         end
         ST_RST: begin
            if (cnt_zero_c) state_nxt = ST_PWROFF;
         end
         ST_PWROFF: begin
            if (!pwr_good) state_nxt = ST_OFF;
            else if (tmo_c) begin
               state_nxt = ST_OFF;
               err_set_c = 1'b1;
            end
         end
         ST_OFF: begin
            if (!sleep_req) state_nxt = ST_PWRON;
         end
         ST_PWRON: begin
            // A timeout here only flags; the supply must still come up.
            if (pwr_good)   state_nxt = ST_PWR_SETTLE;
            else if (tmo_c) err_set_c = 1'b1;
         end
         ST_PWR_SETTLE: begin
            if (cnt_zero_c) state_nxt = ST_RESTORE;
         end
         ST_RESTORE: begin
            if (cnt_zero_c) state_nxt = ST_UNISO;
         end
         ST_UNISO: begin
            if (cnt_zero_c) state_nxt = ST_REL_PD;
         end
         ST_REL_PD: begin
            if (!pd_ack) state_nxt = ST_REL_STOP;
            else if (tmo_c) begin
               state_nxt = ST_ON;
               err_set_c = 1'b1;
            end
         end
         ST_REL_STOP: begin
            if (!rreg_stop_ack) state_nxt = ST_ON;
            else if (tmo_c) begin
               state_nxt = ST_ON;
               err_set_c = 1'b1;
            end
         end
         default: state_nxt = ST_ON;
      endcase

      // Reload on every state change: dwell length or acknowledge budget.
      if (state_nxt != state) begin
         case (state_nxt)
            ST_SAVE:                                 cnt_nxt = SAVE_LD;
            ST_RESTORE:                              cnt_nxt = RESTORE_LD;
            ST_ISO, ST_RST, ST_PWR_SETTLE, ST_UNISO: cnt_nxt = SETTLE_LD;
            default:                                 cnt_nxt = TMO_LD;
         endcase
      end
   end

   // Output decode from the next state so outputs register with the state.
   always_comb begin
      stop_c    = 1'b0;
      pdreq_c   = 1'b0;
      save_c    = 1'b0;
      restore_c = 1'b0;
      iso_c     = 1'b0;
      rstn_c    = 1'b1;
      pwren_c   = 1'b1;
      asleep_c  = 1'b0;
      busy_c    = 1'b1;

      case (state_nxt)
         ST_ON: busy_c = 1'b0;
         ST_STOP: stop_c = 1'b1;
         ST_DRAIN: begin
            stop_c  = 1'b1;
            pdreq_c = 1'b1;
         end
         ST_SAVE: begin
            stop_c  = 1'b1;
            pdreq_c = 1'b1;
            save_c  = 1'b1;
         end
         ST_ISO: begin
            stop_c  = 1'b1;
            pdreq_c = 1'b1;
            iso_c   = 1'b1;
         end
         ST_RST, ST_PWRON, ST_PWR_SETTLE: begin
            stop_c  = 1'b1;
            pdreq_c = 1'b1;
            iso_c   = 1'b1;
            rstn_c  = 1'b0;
         end
         ST_PWROFF, ST_OFF: begin
            stop_c   = 1'b1;
            pdreq_c  = 1'b1;
            iso_c    = 1'b1;
            rstn_c   = 1'b0;
            pwren_c  = 1'b0;
            asleep_c = (state_nxt == ST_OFF);
            busy_c   = (state_nxt != ST_OFF);
         end
         ST_RESTORE: begin
            stop_c    = 1'b1;
            pdreq_c   = 1'b1;
            iso_c     = 1'b1;
            restore_c = 1'b1;
         end
         ST_UNISO: begin
            stop_c  = 1'b1;
            pdreq_c = 1'b1;
         end
         ST_REL_PD: stop_c = 1'b1;
         ST_REL_STOP: ;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dhm_pwr_seq.sv
// Self-checking bench for dhm_pwr_seq: directed scenarios plus randomized
// sleep/ack timing, checked every cycle against a phase-table reference model.
module tb_dhm_pwr_seq;

   localparam int SAVE_CYC    = 2;
   localparam int RESTORE_CYC = 2;
   localparam int ISO_SETTLE  = 4;
   localparam int TIMEOUT     = 16;

   // Model phases in sequence order; output rules are phase ranges.
   localparam int P_ON = 0, P_STOP = 1, P_DRAIN = 2, P_SAVE = 3, P_ISO = 4,
                  P_RST = 5, P_PWROFF = 6, P_OFF = 7, P_PWRON = 8,
                  P_SETTLE = 9, P_RESTORE = 10, P_UNISO = 11, P_RELPD = 12,
                  P_RELST = 13;

   logic clk = 1'b0;
   logic reset_n;
   logic sleep_req;
   logic rreg_stop_ack;
   logic pd_ack;
   logic pwr_good;
   logic rreg_stop_req;
   logic pd_req;
   logic rreg_save;
   logic rreg_restore;
   logic pd_iso;
   logic pd_iso_n;
   logic pd_reset_n;
   logic pwr_en;
   logic asleep;
   logic busy;
   logic err;

   dhm_pwr_seq #(
      .SAVE_CYC    (SAVE_CYC),
      .RESTORE_CYC (RESTORE_CYC),
      .ISO_SETTLE  (ISO_SETTLE),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sleep_req     (sleep_req),
      .rreg_stop_ack (rreg_stop_ack),
      .pd_ack        (pd_ack),
      .pwr_good      (pwr_good),
      .rreg_stop_req (rreg_stop_req),
      .pd_req        (pd_req),
      .rreg_save     (rreg_save),
      .rreg_restore  (rreg_restore),
      .pd_iso        (pd_iso),
      .pd_iso_n      (pd_iso_n),
      .pd_reset_n    (pd_reset_n),
      .pwr_en        (pwr_en),
      .asleep        (asleep),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int ph     = P_ON;
   int left   = 0;
   int waited = 0;
   bit m_err  = 1'b0;

   // Environment (core / power switch responder)
   int d_sa = 3, d_pa = 3, d_pg = 3;
   int c_sa = 0, c_pa = 0, c_pg = 0;
   bit hold_sa0 = 1'b0, hold_pa0 = 1'b0, hold_pg1 = 1'b0;

   // Scenario observation
   int   cyc = 0, save_cnt = 0, rest_cnt = 0, pg_cyc = 0, rs_cyc = 0;
   bit   touched = 1'b0;
   logic prev_rstn = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // {stop, pd_req, save, restore, iso, iso_n, rst_n, pwr_en, asleep, busy, err}
   function automatic logic [10:0] exp_vec(input int p, input bit e);
      logic stop, pdr, sv, rs, iso, rstn, pwr, slp, bsy;
      stop = (p >= P_STOP)  && (p <= P_RELPD);
      pdr  = (p >= P_DRAIN) && (p <= P_UNISO);
      sv   = (p == P_SAVE);
      rs   = (p == P_RESTORE);
      iso  = (p >= P_ISO)   && (p <= P_RESTORE);
      rstn = !((p >= P_RST) && (p <= P_SETTLE));
      pwr  = !((p == P_PWROFF) || (p == P_OFF));
      slp  = (p == P_OFF);
      bsy  = !((p == P_ON) || (p == P_OFF));
      return {stop, pdr, sv, rs, iso, !iso, rstn, pwr, slp, bsy, e};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {rreg_stop_req, pd_req, rreg_save, rreg_restore, pd_iso, pd_iso_n,
              pd_reset_n, pwr_en, asleep, busy, err};
   endfunction

   task automatic model_reset();
      ph = P_ON; left = 0; waited = 0; m_err = 1'b0;
   endtask

   // One clock of the reference model from the inputs seen at the next edge.
   task automatic model_step(input logic sr, input logic sa, input logic pa, input logic pg);
      int nx;
      bit to;
      nx = ph;
      to = 1'b0;
      if (ph == P_STOP || ph == P_DRAIN || ph == P_PWROFF || ph == P_PWRON ||
          ph == P_RELPD || ph == P_RELST) begin
         waited++;
`ifdef DHM_PWR_SEQ_TIMEOUT_EN
         to = (waited >= TIMEOUT);
`endif
      end
      if (ph == P_SAVE || ph == P_ISO || ph == P_RST || ph == P_SETTLE ||
          ph == P_RESTORE || ph == P_UNISO) begin
         left--;
         if (left == 0) nx = ph + 1;
      end
      case (ph)
         P_ON:     if (sr) nx = P_STOP;
         P_STOP:   if (!sr) nx = P_RELPD; else if (sa) nx = P_DRAIN;
                   else if (to) begin nx = P_RELPD; m_err = 1'b1; end
         P_DRAIN:  if (!sr) nx = P_RELPD; else if (pa) nx = P_SAVE;
                   else if (to) begin nx = P_RELPD; m_err = 1'b1; end
         P_PWROFF: if (!pg) nx = P_OFF; else if (to) begin nx = P_OFF; m_err = 1'b1; end
         P_OFF:    if (!sr) nx = P_PWRON;
         P_PWRON:  if (pg) nx = P_SETTLE; else if (to) m_err = 1'b1;
         P_RELPD:  if (!pa) nx = P_RELST; else if (to) begin nx = P_ON; m_err = 1'b1; end
         P_RELST:  if (!sa) nx = P_ON; else if (to) begin nx = P_ON; m_err = 1'b1; end
         default: ;
      endcase
      if (nx != ph) begin
         waited = 0;
         left   = (nx == P_SAVE) ? SAVE_CYC : (nx == P_RESTORE) ? RESTORE_CYC : ISO_SETTLE;
      end
      ph = nx;
   endtask

   // Acknowledges follow their requests after a programmable number of cycles.
   task automatic env_update();
      if (hold_sa0) begin
         rreg_stop_ack = 1'b0; c_sa = 0;
      end else if (rreg_stop_ack != rreg_stop_req) begin
         if (c_sa >= d_sa) begin rreg_stop_ack = rreg_stop_req; c_sa = 0; end
         else c_sa++;
      end else c_sa = 0;

      if (hold_pa0) begin
         pd_ack = 1'b0; c_pa = 0;
      end else if (pd_ack != pd_req) begin
         if (c_pa >= d_pa) begin pd_ack = pd_req; c_pa = 0; end
         else c_pa++;
      end else c_pa = 0;

      if (hold_pg1) begin
         pwr_good = 1'b1; c_pg = 0;
      end else if (pwr_good != pwr_en) begin
         if (c_pg >= d_pg) begin
            if (!pwr_good && pwr_en) pg_cyc = cyc;
            pwr_good = pwr_en; c_pg = 0;
         end else c_pg++;
      end else c_pg = 0;
   endtask

   task automatic cycle();
      logic inv_n;
      env_update();
      model_step(sleep_req, rreg_stop_ack, pd_ack, pwr_good);
      @(negedge clk);
      cyc++;
      chk("outs", 32'(dut_vec()), 32'(exp_vec(ph, m_err)));
      inv_n = ~pd_iso;
      chk("iso_n", 32'(pd_iso_n), 32'(inv_n));
      chk("inv_iso", 32'(pd_iso | (pd_reset_n & pwr_en)), 32'd1);
      chk("inv_overlap", 32'(rreg_save & rreg_restore), 32'd0);
      chk("inv_save", 32'(rreg_save & (pd_iso | !pwr_en)), 32'd0);
      save_cnt += int'(rreg_save);
      rest_cnt += int'(rreg_restore);
      if (pd_iso || rreg_save || !pwr_en || !pd_reset_n) touched = 1'b1;
      if (pd_reset_n && !prev_rstn) rs_cyc = cyc;
      prev_rstn = pd_reset_n;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0: return asleep == 1'b1;
         1: return (busy == 1'b0) && (asleep == 1'b0);
         2: return pd_req == 1'b1;
         3: return rreg_save == 1'b1;
         4: return pwr_en == 1'b0;
         default: return err == 1'b1;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int which, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         cycle();
         hit = cond(which);
      end
      chk({"wait_", tag}, 32'(hit), 32'd1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("reset_vals", 32'(dut_vec()), 32'(exp_vec(P_ON, 1'b0)));
      model_reset();
      hold_sa0 = 1'b0; hold_pa0 = 1'b0; hold_pg1 = 1'b0;
      sleep_req = 1'b0; rreg_stop_ack = 1'b0; pd_ack = 1'b0; pwr_good = 1'b1;
      c_sa = 0; c_pa = 0; c_pg = 0;
      prev_rstn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      sleep_req = 1'b0; rreg_stop_ack = 1'b0; pd_ack = 1'b0; pwr_good = 1'b1;
      #1;
      do_reset();
      repeat (3) cycle();

      // Full sleep with acks after 3 cycles
      save_cnt = 0;
      sleep_req = 1'b1;
      wait_for("asleep", 0, 200);
      chk("save_len", 32'(save_cnt), 32'(SAVE_CYC));

      // Wake with pwr_good rising 5 cycles after pwr_en; pwr_good is sampled
      // one edge after being driven, then ISO_SETTLE cycles to reset release.
      d_pg = 5; rest_cnt = 0;
      sleep_req = 1'b0;
      wait_for("on_after_wake", 1, 200);
      chk("restore_len", 32'(rest_cnt), 32'(RESTORE_CYC));
      chk("pg_to_rstn", 32'(rs_cyc - pg_cyc), 32'(ISO_SETTLE + 1));
      d_pg = 3;

      // Abort in DRAIN with pd_ack held low: no domain-side action at all
      touched = 1'b0; hold_pa0 = 1'b1;
      sleep_req = 1'b1;
      wait_for("drain", 2, 50);
      repeat (3) cycle();
      sleep_req = 1'b0;
      wait_for("on_after_abort", 1, 50);
      chk("abort_clean", 32'(touched), 32'd0);
      hold_pa0 = 1'b0;
      repeat (5) cycle();

      // Drop sleep_req during SAVE: completes to OFF then wakes
      sleep_req = 1'b1;
      wait_for("save", 3, 100);
      sleep_req = 1'b0;
      wait_for("asleep_after_drop", 0, 100);
      wait_for("on_after_drop", 1, 200);

      // Asynchronous reset in PWROFF
      hold_pg1 = 1'b1;
      sleep_req = 1'b1;
      wait_for("pwroff", 4, 200);
      do_reset();
      repeat (3) cycle();

`ifdef DHM_PWR_SEQ_TIMEOUT_EN
      // Stop ack never returns: err after TIMEOUT cycles in STOP, abort to ON
      begin
         int stop_n;
         stop_n = 0;
         hold_sa0 = 1'b1;
         sleep_req = 1'b1;
         for (int i = 0; i < 60 && !err; i++) begin
            cycle();
            if (rreg_stop_req && !err) stop_n++;
         end
         chk("err_set", 32'(err), 32'd1);
         chk("stop_cycles", 32'(stop_n), 32'(TIMEOUT));
         sleep_req = 1'b0;
         hold_sa0 = 1'b0;
         wait_for("on_after_tmo", 1, 50);
         repeat (5) cycle();
         chk("err_sticky", 32'(err), 32'd1);
         do_reset();
         chk("err_cleared", 32'(err), 32'd0);
      end
`endif

      // Randomized sleep levels and acknowledge timing
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         sleep_req = 1'($urandom_range(0, 1));
`ifdef DHM_PWR_SEQ_TIMEOUT_EN
         d_sa = $urandom_range(0, 20);
         d_pa = $urandom_range(0, 20);
         d_pg = $urandom_range(0, 20);
`else
         d_sa = $urandom_range(0, 6);
         d_pa = $urandom_range(0, 6);
         d_pg = $urandom_range(0, 6);
`endif
         hold_sa0 = ($urandom_range(0, 9) == 0);
         hold_pa0 = ($urandom_range(0, 9) == 0);
         hold_pg1 = ($urandom_range(0, 9) == 0);
         len = $urandom_range(5, 60);
         for (int i = 0; i < len; i++) cycle();
      end

      hold_sa0 = 1'b0; hold_pa0 = 1'b0; hold_pg1 = 1'b0;
      d_sa = 2; d_pa = 2; d_pg = 2;
      sleep_req = 1'b0;
      wait_for("final_on", 1, 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dhm_pwr_seq.md
Name: dhm_pwr_seq

Overview:
- Power-down/power-up sequencer for the dhm datapath's switchable core domain.
- Takes a single software sleep request level and drives, in a fixed order, the domain's control inputs: stop request, power-down request, retention save/restore, isolation, domain reset and power-switch enable.
- Waits on each handshake acknowledge before advancing. Sits beside the dhm unit in the always-on domain, clocked by the same clock.

Parameters:
- SAVE_CYC, 2, cycles rreg_save is held high (1..15)
- RESTORE_CYC, 2, cycles rreg_restore is held high (1..15)
- ISO_SETTLE, 4, cycles between isolation assert and reset/power actions, and between power-good and reset release (1..15)
- TIMEOUT, 1024, max wait cycles on any acknowledge (used only with the optional feature; 16..65535)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sleep_req  in  1  level; 1 = put core domain to sleep, 0 = keep/bring awake
- rreg_stop_ack  in  1  core has stopped accepting new traffic
- pd_ack  in  1  bypass/core power-down handshake acknowledge
- pwr_good  in  1  power switch status; 1 = domain supply up
- rreg_stop_req  out  1  stop request to the core
- pd_req  out  1  power-down request
- rreg_save  out  1  retention save strobe
- rreg_restore  out  1  retention restore strobe
- pd_iso  out  1  isolation enable
- pd_iso_n  out  1  always the complement of pd_iso, from a separate flop
- pd_reset_n  out  1  domain reset, active low
- pwr_en  out  1  power switch enable
- asleep  out  1  1 only in state OFF
- busy  out  1  1 in any state other than ON and OFF
- err  out  1  sticky timeout flag (0 when the feature is compiled out)

Behaviour:
- Reset values: state ON; pwr_en=1, pd_reset_n=1, pd_iso=0, pd_iso_n=1; rreg_stop_req, pd_req, rreg_save, rreg_restore, asleep, busy and err all 0.
- All outputs are registered. A state change is visible on the outputs one cycle after the enabling condition is sampled.
- One down-counter, 16 bits, is shared by the SAVE, ISO, RST, RESTORE and UNISO dwell states.
- Sleep sequence:
  - ON: when sleep_req=1 -> STOP.
  - STOP: rreg_stop_req=1; advance to DRAIN when rreg_stop_ack=1.
  - DRAIN: also pd_req=1; advance to SAVE when pd_ack=1.
  - SAVE: rreg_save=1 for exactly SAVE_CYC cycles -> ISO.
  - ISO: pd_iso=1 / pd_iso_n=0; wait ISO_SETTLE cycles -> RST.
  - RST: pd_reset_n=0; wait ISO_SETTLE cycles -> PWROFF.
  - PWROFF: pwr_en=0; advance to OFF when pwr_good=0.
- Wake sequence:
  - OFF: when sleep_req=0 -> PWRON.
  - PWRON: pwr_en=1; after pwr_good=1, wait ISO_SETTLE cycles, then pd_reset_n=1 -> RESTORE.
  - RESTORE: rreg_restore=1 for RESTORE_CYC cycles -> UNISO.
  - UNISO: pd_iso=0 / pd_iso_n=1; wait ISO_SETTLE cycles -> RELEASE.
  - RELEASE: pd_req=0; once pd_ack=0, rreg_stop_req=0; once rreg_stop_ack=0 -> ON.
- Abort: if sleep_req falls in STOP or DRAIN, go to RELEASE. No save, isolation or power action occurs.
- No abort from SAVE onward: the sleep sequence always completes to OFF. Wake then starts on the next cycle if sleep_req=0.
- sleep_req is ignored during the wake states PWRON..RELEASE. After reaching ON it is re-evaluated.
- Invariants:
  - pd_iso is 1 whenever pd_reset_n=0 or pwr_en=0.
  - rreg_save and rreg_restore are never high together.
  - rreg_save is high only while pd_iso=0 and pwr_en=1.
- Asserting reset_n mid-sequence returns immediately to the reset values, including pwr_en=1 and pd_iso=0. The system must hold the domain in reset externally as well.

Optional Feature:
- Macro DHM_PWR_SEQ_TIMEOUT_EN.
- When defined:
  - Each acknowledge wait (STOP, DRAIN, PWROFF, PWRON before pwr_good, both RELEASE waits) counts cycles.
  - On reaching TIMEOUT cycles, err is set. It stays set until reset_n.
  - STOP/DRAIN timeout -> RELEASE (abort).
  - PWROFF timeout -> OFF.
  - PWRON timeout -> stays in PWRON with err=1.
  - RELEASE timeout -> ON.
- When not defined: waits are unbounded and err is tied to 0.

Test Plan:
- Reset, then sleep_req=1 with acks returned after 3 cycles -> outputs follow STOP, DRAIN, SAVE (rreg_save high exactly 2 cycles), ISO, RST, PWROFF in order; asleep=1 after pwr_good=0.
- From OFF, sleep_req=0 with pwr_good rising 5 cycles later -> pd_reset_n rises 4 cycles after pwr_good; rreg_restore high 2 cycles; pd_iso falls; pd_req then rreg_stop_req drop; busy=0 and asleep=0 in ON.
- sleep_req pulse dropped while in DRAIN with pd_ack held 0 -> pd_iso, rreg_save, pwr_en and pd_reset_n never change; rreg_stop_req clears; back in ON.
- sleep_req dropped during SAVE -> sequence reaches OFF, then wakes back to ON; rreg_save and rreg_restore never overlap.
- reset_n asserted in PWROFF -> same cycle: pwr_en=1, pd_iso=0, pd_iso_n=1, pd_reset_n=1, state ON.
- With DHM_PWR_SEQ_TIMEOUT_EN, TIMEOUT=16, rreg_stop_ack held 0 -> err=1 after 16 cycles in STOP; aborts to ON; err stays 1 until reset.
